// File: rtl/rslice_pkg.sv
// Shared types for the m00 read-data slice: widths, rresp encoding, beat payload, group helper.
package rslice_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned GRP_W  = 2;
    localparam int unsigned GRP_N  = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } rresp_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              last;
        rresp_e            resp;
    } beat_t;

    // Burst tracking group is the top two ID bits.
    function automatic logic [GRP_W-1:0] grp_of(input logic [ID_W-1:0] id);
        return id[ID_W-1 -: GRP_W];
    endfunction

endpackage

// File: rtl/rdata_slice_m4_if.sv
// AXI R-channel bundle (id/data/last/resp/valid/ready) with master and slave views.
interface rdata_slice_m4_if;

    logic [rslice_pkg::ID_W-1:0]   rid;
    logic [rslice_pkg::DATA_W-1:0] rdata;
    logic                          rlast;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (output rid, rdata, rlast, rresp, rvalid, input rready);
    modport slave  (input rid, rdata, rlast, rresp, rvalid, output rready);

endinterface

// File: rtl/rslice_skid2.sv
// Two-entry valid/ready skid buffer for beat_t; in_ready and all outputs are registered.
module rslice_skid2
    import rslice_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  in_ready,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_ready
);

    logic  skid_full;
    beat_t skid_beat;
    logic  in_fire;
    logic  load_main;

    assign in_fire   = in_valid & in_ready;
    assign load_main = ~out_valid | out_ready;

    // in_ready always mirrors ~skid_full, so no input arrives while the skid drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
            skid_full <= 1'b0;
            skid_beat <= '0;
            in_ready  <= 1'b1;
        end else if (load_main) begin
            if (skid_full) begin
                out_beat  <= skid_beat;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_beat <= in_beat;
                end
            end
            in_ready <= 1'b1;
        end else if (in_fire) begin
            skid_beat <= in_beat;
            skid_full <= 1'b1;
            in_ready  <= 1'b0;
        end
    end

endmodule

// File: rtl/rdata_slice_m4.sv
// Registered R-channel slice for master 0 with per-group burst tracking and rlast checking.
// Optional: RSLICE_FORCE_LAST_EN forces rlast on the final beat and drains beats after a late retire.
module rdata_slice_m4
    import rslice_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ar_fire,
    input  logic [ID_W-1:0]      ar_id,
    input  logic [LEN_W-1:0]     ar_len,
    output logic                 ar_stall,
    rdata_slice_m4_if.slave      s,
    rdata_slice_m4_if.master     m00_axi,
    output logic                 err_early,
    output logic                 err_late,
    output logic                 err_orphan,
    input  logic                 err_clr,
    output logic [GRP_N-1:0]     busy_grp
);

    logic [GRP_N-1:0]            busy, busy_n;
    logic [GRP_N-1:0][LEN_W-1:0] len, len_n;
    logic [GRP_N-1:0][LEN_W-1:0] cnt, cnt_n;
`ifdef RSLICE_FORCE_LAST_EN
    logic [GRP_N-1:0]            drain, drain_n;
`endif
    logic [GRP_W-1:0] sg, ag;
    logic             accept;
    logic             set_early, set_late, set_orphan;
    logic             drop, force_last;
    beat_t            in_beat, out_beat;
    logic             out_valid;

    assign sg       = grp_of(s.rid);
    assign ag       = grp_of(ar_id);
    assign accept   = s.rvalid & s.rready;
    assign ar_stall = busy[ag];
    assign busy_grp = busy;

    // Per-beat check against the group's expected length, then AR install.
    always_comb begin
        busy_n     = busy;
        len_n      = len;
        cnt_n      = cnt;
`ifdef RSLICE_FORCE_LAST_EN
        drain_n    = drain;
`endif
        set_early  = 1'b0;
        set_late   = 1'b0;
        set_orphan = 1'b0;
        drop       = 1'b0;
        force_last = 1'b0;
        if (accept) begin
`ifdef RSLICE_FORCE_LAST_EN
            if (drain[sg]) begin
                drop = 1'b1;
                if (s.rlast) begin
                    drain_n[sg] = 1'b0;
                end
            end else
`endif
            if (!busy[sg]) begin
                set_orphan = 1'b1;
            end else if (cnt[sg] == len[sg]) begin
                busy_n[sg] = 1'b0;
`ifdef RSLICE_FORCE_LAST_EN
                force_last = 1'b1;
                if (!s.rlast) begin
                    drain_n[sg] = 1'b1;
                end
`endif
                if (!s.rlast) begin
                    set_late = 1'b1;
                end
            end else if (s.rlast) begin
                set_early  = 1'b1;
                busy_n[sg] = 1'b0;
            end else begin
                cnt_n[sg] = cnt[sg] + LEN_W'(1);
            end
        end
        // A group retiring this cycle may take the new burst; a still-busy one ignores it.
        if (ar_fire && !busy_n[ag]) begin
            busy_n[ag] = 1'b1;
            len_n[ag]  = ar_len;
            cnt_n[ag]  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            len        <= '0;
            cnt        <= '0;
`ifdef RSLICE_FORCE_LAST_EN
            drain      <= '0;
`endif
            err_early  <= 1'b0;
            err_late   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            busy <= busy_n;
            len  <= len_n;
            cnt  <= cnt_n;
`ifdef RSLICE_FORCE_LAST_EN
            drain <= drain_n;
`endif
            if (err_clr) begin
                err_early  <= 1'b0;
                err_late   <= 1'b0;
                err_orphan <= 1'b0;
            end else begin
                err_early  <= err_early  | set_early;
                err_late   <= err_late   | set_late;
                err_orphan <= err_orphan | set_orphan;
            end
        end
    end

    always_comb begin
        in_beat      = '0;
        in_beat.id   = s.rid;
        in_beat.data = s.rdata;
        in_beat.last = s.rlast | force_last;
        in_beat.resp = rresp_e'(s.rresp);
    end

    rslice_skid2 u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s.rvalid & ~drop),
        .in_beat   (in_beat),
        .in_ready  (s.rready),
        .out_valid (out_valid),
        .out_beat  (out_beat),
        .out_ready (m00_axi.rready)
    );

    assign m00_axi.rvalid = out_valid;
    assign m00_axi.rid    = out_beat.id;
    assign m00_axi.rdata  = out_beat.data;
    assign m00_axi.rlast  = out_beat.last;
    assign m00_axi.rresp  = out_beat.resp;

endmodule
